// File: rtl/seq_ram_writer_16x4.sv
// Records one-hot button presses into a 16x4 register memory with a
// registered read port that matches the sequence-ROM read convention.
module seq_ram_writer_16x4 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] botoes,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              write_done,
  output logic              err,
  output logic              full,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_WRITE,
    S_ERROR,
    S_WAIT_RELEASE,
    S_FULL
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                mem_we;

  function automatic logic is_one_hot(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    data_d  = data_q;
    mem_we  = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      count_d = '0;
      data_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) state_d = S_WAIT_PRESS;
        end
        S_WAIT_PRESS: begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (botoes == '0) begin
            state_d = S_WAIT_PRESS;
          end else if (is_one_hot(botoes)) begin
            data_d  = botoes;
            state_d = S_WRITE;
          end else begin
            state_d = S_ERROR;
          end
        end
        S_WRITE: begin
          mem_we  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          // The 16th entry parks the FSM in FULL so count stops at 2**ADDR_W.
          state_d = (count_q == (ADDR_W + 1)'(DEPTH - 1)) ? S_FULL : S_WAIT_RELEASE;
        end
        S_ERROR: begin
          state_d = S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (botoes == '0) state_d = S_WAIT_PRESS;
        end
        S_FULL: begin
          state_d = S_FULL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Read samples the pre-write contents, so a same-address read returns old data.
  always_comb begin
    rd_data_d = mem_q[rd_address];
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (mem_we) begin
      mem_d[ptr_q] = data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      count_q   <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign count      = count_q;
  assign write_done = (state_q == S_WRITE);
  assign err        = (state_q == S_ERROR);
  assign full       = (state_q == S_FULL);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FULL);

endmodule

// File: doc/seq_ram_writer_16x4.md
Name: seq_ram_writer_16x4

Overview:
Records a player's button sequence into an internal 16x4 synchronous memory. Each accepted press is stored as a one-hot nibble (0001, 0010, 0100, 1000) at consecutive addresses. This is the write side of the one-hot sequence-memory format used by the game datapath. A synchronous read port with the same address/data convention as the pre-programmed sequence ROM lets the comparator read back recorded sequences directly.

Parameters:
ADDR_W, 4, address width; memory depth is 2**ADDR_W (16).
DATA_W, 4, entry width; one bit per button.

Ports:
clock  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
clear  input  1  synchronous restart: pointer/count/full to 0, state IDLE; memory contents kept.
enable  input  1  arms recording; sampled in IDLE and WAIT_PRESS.
botoes  input  DATA_W  button levels, already debounced and synchronised; 1 = pressed.
rd_address  input  ADDR_W  read address.
rd_data  output  DATA_W  registered read data.
count  output  ADDR_W+1  number of entries written (0..16).
write_done  output  1  high for exactly the one cycle in state WRITE.
err  output  1  high for exactly the one cycle in state ERROR (non-one-hot press).
full  output  1  high while in state FULL.
busy  output  1  high in any state other than IDLE and FULL.

Behaviour:
- Reset (synchronous, overrides clear and enable):
  - state=IDLE; ptr=0; count=0; data_reg=0; rd_data=0.
  - All 16 memory entries = 0000.
  - Outputs write_done, err, full and busy are all 0.
- clear: same as reset except memory and rd_data are untouched. reset has priority over clear; clear has priority over all FSM transitions.
- FSM transitions (Moore outputs):
  - IDLE: enable=1 -> WAIT_PRESS.
  - WAIT_PRESS:
    - enable=0 -> IDLE, regardless of botoes.
    - Else botoes=0 -> stay.
    - Else botoes one-hot -> data_reg<=botoes, go to WRITE.
    - Else (two or more bits set) -> ERROR.
  - WRITE (1 cycle): on exit edge, mem[ptr]<=data_reg, ptr<=ptr+1 (wraps 15->0), count<=count+1. Next state is FULL if count was 15, else WAIT_RELEASE.
  - ERROR (1 cycle): no memory write; ptr and count unchanged. Next state WAIT_RELEASE.
  - WAIT_RELEASE: botoes=0 -> WAIT_PRESS; otherwise stay. enable is ignored here, so one held press is never recorded twice.
  - FULL: stays until reset or clear. botoes and enable are ignored.
- Latency: press visible at edge k (state WAIT_PRESS) -> WRITE during cycle k+1 -> memory and count updated at edge k+2.
- Read port:
  - rd_data <= mem[rd_address] on every posedge, one-cycle latency, independent of FSM state.
  - Read-during-write to the same address returns the old content; the new value is visible on the following read.
- Width rules:
  - count is ADDR_W+1 bits and saturates at 16 via the FULL state; it never wraps.
  - ptr is ADDR_W bits.
- Button changes during WRITE or ERROR are ignored; data_reg is held.

Test Plan:
1. Reset then enable=1; press 0001, 0010, 0100, 1000, releasing to 0 between presses -> 4 write_done pulses, count=4. Reading addresses 0..3 returns 0001/0010/0100/1000 one cycle after the address is applied; address 4 reads 0000.
2. Press 0110 in WAIT_PRESS -> err=1 for one cycle, count unchanged, no memory change. After release, press 0100 -> written at the next address.
3. Hold 1000 for 10 cycles -> exactly one write_done and count+1. No second write until botoes returns to 0000.
4. Record 16 valid presses -> the 16th WRITE sets full=1 and count=16, with busy=0 in FULL. A 17th press causes no write and no err. clear -> count=0, full=0, all 16 entries still readable.
5. After 3 writes, assert reset mid-WAIT_RELEASE -> next cycle count=0, state IDLE, all reads return 0000.
6. enable=0 while in WAIT_PRESS -> IDLE next cycle; a press there is not recorded. Re-enable -> recording resumes at the same ptr.
